stream_mux_rr: RTL

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes, a registered output stage and either fixed-select or round-robin channel choice. It generalises the team's 2:1 combinational `mux` into a sequential block. Its first use is merging the result streams of several approximate-adder lanes onto one bus for error-statistics capture.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/stream_mux_rr.sv | 74 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the streaming multiplexer family.
// Included first so every mux block sees the same mode encoding.
package mux_pkg;

  localparam int MUX_MODE_FIXED = 0;
  localparam int MUX_MODE_RR    = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping, produces a one-hot grant plus its binary index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  int          j;
  logic [SW-1:0] jj;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = SW'(j);
      if (en && !found && req[jj]) begin
        gnt[jj] = 1'b1;
        gnt_idx = jj;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage and
// fixed-select or round-robin channel choice.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int N    = 4,
  parameter  int MODE = 1,
  localparam int SW   = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic [SW-1:0] out_chan,
  input  logic          out_ready
);

  logic          load;
  logic          en;
  logic          xfer;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] ptr;
  logic [SW-1:0] arb_ptr;

  assign load = !out_valid || out_ready;
  // rst_n gates the grant so no in_ready leaks out during reset
  assign en   = load && rst_n;

  always_comb begin
    req     = in_valid;
    arb_ptr = ptr;
    if (MODE == MUX_MODE_FIXED) begin
      req     = '0;
      arb_ptr = '0;
      if (int'(sel) < N) req[sel] = in_valid[sel];
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .ptr     (arb_ptr),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;
  assign xfer     = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= in_data[int'(gnt_idx)*W +: W];
      out_chan  <= gnt_idx;
      out_valid <= 1'b1;
      if (MODE == MUX_MODE_RR)
        ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
